// File: rtl/isq_sched_if.sv
// Issue-queue scheduler bus: dispatch side, wakeup/stall/flush controls,
// and the registered issue/status outputs, bundled for the isq_sched block.
interface isq_sched_if #(
   parameter int ISQ_DEPTH        = 16,
   parameter int ISQ_IDX_BITS_NUM = 4,
   parameter int INST_WIDTH       = 67,
   parameter int DISP_PORT        = 4,
   parameter int ISS_PORT         = 2
) ();
   logic                               flush;
   logic [DISP_PORT-1:0]               disp_vld;
   logic [DISP_PORT-1:0]               disp_wat;
   logic [INST_WIDTH*DISP_PORT-1:0]    disp_inst_flat;
   logic                               disp_rdy;
   logic [ISQ_DEPTH-1:0]               wakeup;
   logic                               iss_stall;
   logic [ISS_PORT-1:0]                iss_vld;
   logic [ISS_PORT*ISQ_IDX_BITS_NUM-1:0] iss_idx_flat;
   logic [ISS_PORT*INST_WIDTH-1:0]     iss_inst_flat;
   logic [ISQ_DEPTH-1:0]               val_out;
   logic [ISQ_IDX_BITS_NUM:0]          free_cnt;

   // Producer side: rename/dispatch, wakeup network and execute back-pressure
   modport master (
      output flush, disp_vld, disp_wat, disp_inst_flat, wakeup, iss_stall,
      input  disp_rdy, iss_vld, iss_idx_flat, iss_inst_flat, val_out, free_cnt
   );

   // Queue side
   modport slave (
      input  flush, disp_vld, disp_wat, disp_inst_flat, wakeup, iss_stall,
      output disp_rdy, iss_vld, iss_idx_flat, iss_inst_flat, val_out, free_cnt
   );
endinterface

// File: rtl/isq_sched.sv
// Issue queue: compacting multi-port allocation into the lowest free slots,
// per-entry wakeup of outstanding operands, and lowest-index-first select of
// up to ISS_PORT ready entries into registered issue outputs.
module isq_sched #(
   parameter int ISQ_DEPTH        = 16,
   parameter int ISQ_IDX_BITS_NUM = 4,
   parameter int INST_WIDTH       = 67,
   parameter int DISP_PORT        = 4,
   parameter int ISS_PORT         = 2
) (
   input logic       clk,
   input logic       rst_n,
   isq_sched_if.slave bus
);
   localparam int IW = ISQ_IDX_BITS_NUM;
   localparam logic [IW:0] DEPTH_C = (IW+1)'(ISQ_DEPTH);
   localparam logic [IW:0] DISP_C  = (IW+1)'(DISP_PORT);

   // Entry state
   logic [ISQ_DEPTH-1:0]  val_r;
   logic [ISQ_DEPTH-1:0]  wat_r;
   logic [INST_WIDTH-1:0] pay_r [ISQ_DEPTH];

   // Next entry state
   logic [ISQ_DEPTH-1:0]  val_nxt_s;
   logic [ISQ_DEPTH-1:0]  wat_nxt_s;
   logic [INST_WIDTH-1:0] pay_nxt_s [ISQ_DEPTH];

   // Allocation results
   logic                  disp_rdy_s;
   logic                  disp_go_s;
   logic [ISQ_DEPTH-1:0]  wr_en_s;
   logic [ISQ_DEPTH-1:0]  wr_wat_s;
   logic [INST_WIDTH-1:0] wr_pay_s [ISQ_DEPTH];

   // Selection results
   logic [ISQ_DEPTH-1:0]  clr_s;
   logic [ISS_PORT-1:0]   sel_vld_s;
   logic [IW-1:0]         sel_idx_s  [ISS_PORT];
   logic [INST_WIDTH-1:0] sel_inst_s [ISS_PORT];

   // Registered outputs
   logic [IW:0]                 free_cnt_r;
   logic [ISS_PORT-1:0]         iss_vld_r;
   logic [ISS_PORT*IW-1:0]      iss_idx_r;
   logic [ISS_PORT*INST_WIDTH-1:0] iss_inst_r;

   // Number of set bits in an entry vector
   function automatic logic [IW:0] popcnt(input logic [ISQ_DEPTH-1:0] vec);
      logic [IW:0] cnt;
      cnt = '0;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
         cnt = cnt + {{IW{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

   // All-or-nothing dispatch: only accept when every port could be placed
   assign disp_rdy_s = (free_cnt_r >= DISP_C);
   assign disp_go_s  = disp_rdy_s & ~bus.flush;

   // Compact valid dispatch ports onto the lowest-index entries free before the edge
   always_comb begin
      logic [ISQ_DEPTH-1:0] taken_v;
      logic                 found_v;
      taken_v  = val_r;
      found_v  = 1'b0;
      wr_en_s  = '0;
      wr_wat_s = '0;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
         wr_pay_s[i] = '0;
      end
      for (int p = 0; p < DISP_PORT; p++) begin
         found_v = 1'b0;
         for (int i = 0; i < ISQ_DEPTH; i++) begin
            if (disp_go_s && bus.disp_vld[p] && !found_v && !taken_v[i]) begin
               taken_v[i]  = 1'b1;
               found_v     = 1'b1;
               wr_en_s[i]  = 1'b1;
               wr_wat_s[i] = bus.disp_wat[p];
               wr_pay_s[i] = bus.disp_inst_flat[INST_WIDTH*p +: INST_WIDTH];
            end else begin
               found_v = found_v;
            end
         end
      end
   end

   // Pick up to ISS_PORT ready entries, lowest index to lowest port
   always_comb begin
      logic [ISQ_DEPTH-1:0] avail_v;
      logic                 found_v;
      avail_v   = val_r & ~wat_r;
      found_v   = 1'b0;
      clr_s     = '0;
      sel_vld_s = '0;
      for (int j = 0; j < ISS_PORT; j++) begin
         sel_idx_s[j]  = '0;
         sel_inst_s[j] = '0;
      end
      for (int j = 0; j < ISS_PORT; j++) begin
         found_v = 1'b0;
         for (int i = 0; i < ISQ_DEPTH; i++) begin
            if (!bus.iss_stall && !found_v && avail_v[i]) begin
               avail_v[i]    = 1'b0;
               found_v       = 1'b1;
               clr_s[i]      = 1'b1;
               sel_vld_s[j]  = 1'b1;
               sel_idx_s[j]  = IW'(i);
               sel_inst_s[j] = pay_r[i];
            end else begin
               found_v = found_v;
            end
         end
      end
   end

   // Merge dispatch writes, issue clears and wakeups into next entry state
   always_comb begin
      val_nxt_s = val_r;
      wat_nxt_s = wat_r;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
         pay_nxt_s[i] = pay_r[i];
      end
      for (int i = 0; i < ISQ_DEPTH; i++) begin
         if (wr_en_s[i]) begin
            // A freshly written entry takes its wait bit from dispatch, not wakeup
            val_nxt_s[i] = 1'b1;
            wat_nxt_s[i] = wr_wat_s[i];
            pay_nxt_s[i] = wr_pay_s[i];
         end else if (clr_s[i]) begin
            val_nxt_s[i] = 1'b0;
         end else if (bus.wakeup[i] && val_r[i]) begin
            wat_nxt_s[i] = 1'b0;
         end else begin
            val_nxt_s[i] = val_r[i];
         end
      end
   end

   // Entry state, free count and issue registers; flush clears entries and issue valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_r      <= '0;
         wat_r      <= '0;
         free_cnt_r <= DEPTH_C;
         iss_vld_r  <= '0;
         iss_idx_r  <= '0;
         iss_inst_r <= '0;
         for (int i = 0; i < ISQ_DEPTH; i++) begin
            pay_r[i] <= '0;
         end
      end else if (bus.flush) begin
         val_r      <= '0;
         wat_r      <= '0;
         free_cnt_r <= DEPTH_C;
         iss_vld_r  <= '0;
      end else begin
         val_r      <= val_nxt_s;
         wat_r      <= wat_nxt_s;
         free_cnt_r <= DEPTH_C - popcnt(val_nxt_s);
         iss_vld_r  <= sel_vld_s;
         for (int i = 0; i < ISQ_DEPTH; i++) begin
            pay_r[i] <= pay_nxt_s[i];
         end
         for (int j = 0; j < ISS_PORT; j++) begin
            if (sel_vld_s[j]) begin
               iss_idx_r[IW*j +: IW]                 <= sel_idx_s[j];
               iss_inst_r[INST_WIDTH*j +: INST_WIDTH] <= sel_inst_s[j];
            end
         end
      end
   end

   assign bus.disp_rdy      = disp_rdy_s;
   assign bus.iss_vld       = iss_vld_r;
   assign bus.iss_idx_flat  = iss_idx_r;
   assign bus.iss_inst_flat = iss_inst_r;
   assign bus.val_out       = val_r;
   assign bus.free_cnt      = free_cnt_r;
endmodule

// File: tb/tb_isq_sched.sv
// Self-checking bench for isq_sched: directed scenarios plus randomized
// traffic, all compared against a queue-based behavioural model.
module tb_isq_sched;
   localparam int DEPTH = 16;
   localparam int IW    = 4;
   localparam int INW   = 67;
   localparam int DISP  = 4;
   localparam int ISS   = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   isq_sched_if #(.ISQ_DEPTH(DEPTH), .ISQ_IDX_BITS_NUM(IW), .INST_WIDTH(INW),
                  .DISP_PORT(DISP), .ISS_PORT(ISS)) bus ();

   isq_sched #(.ISQ_DEPTH(DEPTH), .ISQ_IDX_BITS_NUM(IW), .INST_WIDTH(INW),
               .DISP_PORT(DISP), .ISS_PORT(ISS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [DEPTH-1:0] m_val;
   logic [DEPTH-1:0] m_wat;
   logic [INW-1:0]   m_pay [DEPTH];
   logic [ISS-1:0]   m_iss_vld;
   logic [IW-1:0]    m_iss_idx [ISS];
   logic [INW-1:0]   m_iss_inst [ISS];
   int               m_free;

   logic [INW-1:0]   pin [DISP];

   task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock edge of the queue, from the rules: free list, ready list, wakeups, dispatch
   task automatic model_step();
      int free_q[$];
      int rdy_q[$];
      int k;
      logic [DEPTH-1:0] nv;
      logic [DEPTH-1:0] nw;
      if (bus.flush) begin
         m_val     = '0;
         m_wat     = '0;
         m_iss_vld = '0;
         m_free    = DEPTH;
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (m_val[i] && !m_wat[i]) rdy_q.push_back(i);
         if (!m_val[i]) free_q.push_back(i);
      end
      nv = m_val;
      nw = m_wat;
      for (int j = 0; j < ISS; j++) begin
         if (!bus.iss_stall && j < rdy_q.size()) begin
            m_iss_vld[j]  = 1'b1;
            m_iss_idx[j]  = IW'(rdy_q[j]);
            m_iss_inst[j] = m_pay[rdy_q[j]];
            nv[rdy_q[j]]  = 1'b0;
         end else begin
            m_iss_vld[j] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.wakeup[i] && m_val[i]) nw[i] = 1'b0;
      end
      if (m_free >= DISP) begin
         k = 0;
         for (int p = 0; p < DISP; p++) begin
            if (bus.disp_vld[p]) begin
               nv[free_q[k]]    = 1'b1;
               nw[free_q[k]]    = bus.disp_wat[p];
               m_pay[free_q[k]] = pin[p];
               k++;
            end
         end
      end
      m_val  = nv;
      m_wat  = nw;
      m_free = DEPTH - $countones(nv);
   endtask

   task automatic cmp_all();
      chk_eq("val_out", 128'(bus.val_out), 128'(m_val));
      chk_eq("free_cnt", 128'(bus.free_cnt), 128'(m_free));
      chk_eq("disp_rdy", 128'(bus.disp_rdy), 128'(m_free >= DISP));
      for (int j = 0; j < ISS; j++) begin
         chk_eq("iss_vld", 128'(bus.iss_vld[j]), 128'(m_iss_vld[j]));
         chk_eq("iss_idx", 128'(bus.iss_idx_flat[IW*j +: IW]), 128'(m_iss_idx[j]));
         chk_eq("iss_inst", 128'(bus.iss_inst_flat[INW*j +: INW]), 128'(m_iss_inst[j]));
      end
   endtask

   task automatic new_payloads();
      logic [95:0] r;
      for (int p = 0; p < DISP; p++) begin
         r = {$urandom, $urandom, $urandom};
         pin[p] = r[INW-1:0];
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance model and DUT, compare
   task automatic cycle(input logic [DISP-1:0] vld, input logic [DISP-1:0] wat,
                        input logic [DEPTH-1:0] wk, input logic stall, input logic fl);
      bus.disp_vld  = vld;
      bus.disp_wat  = wat;
      bus.wakeup    = wk;
      bus.iss_stall = stall;
      bus.flush     = fl;
      for (int p = 0; p < DISP; p++) bus.disp_inst_flat[INW*p +: INW] = pin[p];
      model_step();
      @(posedge clk);
      @(negedge clk);
      cmp_all();
   endtask

   logic [INW-1:0] p1_s;
   logic [INW-1:0] p3_s;

   initial begin
      rst_n              = 1'b0;
      bus.flush          = 1'b0;
      bus.disp_vld       = '0;
      bus.disp_wat       = '0;
      bus.disp_inst_flat = '0;
      bus.wakeup         = '0;
      bus.iss_stall      = 1'b0;
      m_val = '0; m_wat = '0; m_iss_vld = '0; m_free = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_pay[i] = '0;
      for (int j = 0; j < ISS; j++) begin
         m_iss_idx[j]  = '0;
         m_iss_inst[j] = '0;
      end
      repeat (2) @(negedge clk);
      chk_eq("rst_free_cnt", 128'(bus.free_cnt), 128'(16));
      chk_eq("rst_disp_rdy", 128'(bus.disp_rdy), 128'(1));
      chk_eq("rst_iss_vld", 128'(bus.iss_vld), 128'(0));
      chk_eq("rst_val_out", 128'(bus.val_out), 128'(0));
      chk_eq("rst_iss_idx", 128'(bus.iss_idx_flat), 128'(0));
      chk_eq("rst_iss_inst", 128'(bus.iss_inst_flat), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Sparse dispatch compacts ports 1 and 3 into entries 0 and 1
      new_payloads();
      p1_s = pin[1];
      p3_s = pin[3];
      cycle(4'b1010, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("cmp_val", 128'(bus.val_out), 128'(16'h0003));
      chk_eq("cmp_nobypass", 128'(bus.iss_vld), 128'(0));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("cmp_iss_vld", 128'(bus.iss_vld), 128'(2'b11));
      chk_eq("cmp_idx0", 128'(bus.iss_idx_flat[3:0]), 128'(0));
      chk_eq("cmp_idx1", 128'(bus.iss_idx_flat[7:4]), 128'(1));
      chk_eq("cmp_inst0", 128'(bus.iss_inst_flat[INW-1:0]), 128'(p1_s));
      chk_eq("cmp_inst1", 128'(bus.iss_inst_flat[2*INW-1:INW]), 128'(p3_s));
      chk_eq("cmp_free", 128'(bus.free_cnt), 128'(16));

      // Fill to 13 waiting entries: dispatch must be refused entirely
      for (int c = 0; c < 3; c++) begin
         new_payloads();
         cycle(4'b1111, 4'b1111, '0, 1'b0, 1'b0);
      end
      new_payloads();
      cycle(4'b0001, 4'b0001, '0, 1'b0, 1'b0);
      chk_eq("full_free", 128'(bus.free_cnt), 128'(3));
      chk_eq("full_rdy", 128'(bus.disp_rdy), 128'(0));
      new_payloads();
      cycle(4'b1111, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("full_nowrite", 128'(bus.val_out), 128'(16'h1FFF));
      cycle(4'b0000, 4'b0000, 16'h0001, 1'b0, 1'b0);
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("full_iss", 128'(bus.iss_vld), 128'(2'b01));
      chk_eq("full_free4", 128'(bus.free_cnt), 128'(4));
      chk_eq("full_rdy1", 128'(bus.disp_rdy), 128'(1));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b1);

      // Wakeup of entry 5 becomes selectable only one cycle later
      new_payloads();
      cycle(4'b1111, 4'b1111, '0, 1'b0, 1'b0);
      new_payloads();
      cycle(4'b0011, 4'b0011, '0, 1'b0, 1'b0);
      cycle(4'b0000, 4'b0000, 16'h0020, 1'b0, 1'b0);
      chk_eq("wk_same", 128'(bus.iss_vld), 128'(0));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("wk_next_vld", 128'(bus.iss_vld), 128'(2'b01));
      chk_eq("wk_next_idx", 128'(bus.iss_idx_flat[3:0]), 128'(5));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b1);

      // Wakeup coinciding with the write of entry 3: dispatch wait bit wins
      new_payloads();
      cycle(4'b0111, 4'b0111, '0, 1'b0, 1'b0);
      new_payloads();
      cycle(4'b0001, 4'b0001, 16'h0008, 1'b0, 1'b0);
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("race_noiss", 128'(bus.iss_vld), 128'(0));
      chk_eq("race_val", 128'(bus.val_out), 128'(16'h000F));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
      chk_eq("race_noiss2", 128'(bus.iss_vld), 128'(0));
      cycle(4'b0000, 4'b0000, '0, 1'b0, 1'b1);

      // Six ready entries held by stall, then a flush discarding a dispatch
      new_payloads();
      cycle(4'b1111, 4'b0000, '0, 1'b1, 1'b0);
      new_payloads();
      cycle(4'b0011, 4'b0000, '0, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
         cycle(4'b0000, 4'b0000, '0, 1'b1, 1'b0);
         chk_eq("stall_vld", 128'(bus.iss_vld), 128'(0));
         chk_eq("stall_val", 128'(bus.val_out), 128'(16'h003F));
      end
      new_payloads();
      cycle(4'b1111, 4'b0000, '0, 1'b0, 1'b1);
      chk_eq("flush_vld", 128'(bus.iss_vld), 128'(0));
      chk_eq("flush_val", 128'(bus.val_out), 128'(0));
      chk_eq("flush_free", 128'(bus.free_cnt), 128'(16));

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         logic [DISP-1:0]  v;
         logic [DISP-1:0]  w;
         logic [DEPTH-1:0] wk;
         new_payloads();
         v  = DISP'($urandom_range(0, 15));
         w  = DISP'($urandom) & DISP'($urandom);
         wk = DEPTH'($urandom) & DEPTH'($urandom);
         cycle(v, w, wk, ($urandom_range(0, 6) == 0), ($urandom_range(0, 40) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/isq_sched.md
Name: isq_sched

Overview:
- Parametrised next-generation issue queue with real allocation, wakeup and select.
- Accepts up to DISP_PORT renamed instructions per cycle into free slots, lowest index first.
- Tracks per-entry valid and wait bits; clears wait bits on wakeup.
- Each cycle, selects up to ISS_PORT ready entries, lowest index first, and issues them as registered outputs to the functional-unit front end.
- Sits between rename/dispatch and the execute stage.

Parameters:
ISQ_DEPTH, 16, number of entries; must equal 2**ISQ_IDX_BITS_NUM
ISQ_IDX_BITS_NUM, 4, entry index width
INST_WIDTH, 67, instruction payload width
DISP_PORT, 4, dispatch ports per cycle (1..ISQ_DEPTH)
ISS_PORT, 2, issue ports per cycle (1..ISQ_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all entries and issue outputs
disp_vld  in  DISP_PORT  per-port dispatch request
disp_wat  in  DISP_PORT  per-port initial wait bit (1 = operands outstanding)
disp_inst_flat  in  INST_WIDTH*DISP_PORT  payload; port p at bits [INST_WIDTH*(p+1)-1 : INST_WIDTH*p]
disp_rdy  out  1  high when free_cnt >= DISP_PORT
wakeup  in  ISQ_DEPTH  per-entry clear-wait strobe
iss_stall  in  1  suppresses selection this cycle
iss_vld  out  ISS_PORT  registered issue valid
iss_idx_flat  out  ISS_PORT*ISQ_IDX_BITS_NUM  issued entry index per port
iss_inst_flat  out  ISS_PORT*INST_WIDTH  issued payload per port
val_out  out  ISQ_DEPTH  entry valid vector (registered)
free_cnt  out  ISQ_IDX_BITS_NUM+1  number of free entries (registered)

Behaviour:
- Reset, asynchronous:
  - all val=0, wat=0, payload=0
  - iss_vld=0, iss_idx_flat=0, iss_inst_flat=0
  - free_cnt=ISQ_DEPTH, disp_rdy=1
- Dispatch:
  - Occurs at an edge when disp_rdy=1 and flush=0. Ports with disp_vld=1 are compacted: the k-th valid port, counted from port 0, goes to the k-th lowest-index entry with val=0.
  - Written entry gets val=1, wat=disp_wat[p], payload=port p.
  - If disp_rdy=0, all disp_vld are ignored (no partial dispatch).
  - disp_rdy is a combinational compare on registered free_cnt.
- Free-slot visibility: slots freed by issue at edge N are not usable by a dispatch sampled at edge N. The free-slot scan uses pre-edge val.
- Wakeup:
  - At an edge, wakeup[i]=1 with val[i]=1 clears wat[i].
  - Wakeup on an invalid entry is ignored.
  - Wakeup on an entry being written at the same edge is ignored; disp_wat wins.
- Select:
  - Combinational over pre-edge state. Ready = val & ~wat.
  - Port 0 takes the lowest-index ready entry, port 1 the next, and so on.
  - Ports with no candidate select nothing.
  - A wakeup arriving in the same cycle does not make an entry selectable until the next cycle.
- Issue, at the edge when iss_stall=0 and flush=0:
  - Selected entries get val=0.
  - iss_vld[j], iss_idx_flat and iss_inst_flat are registered from selection.
  - Unselected ports get iss_vld[j]=0; idx and inst hold their previous value.
  - When iss_stall=1: no entry is cleared and iss_vld=0 at the next edge.
- Latency:
  - Dispatch with wat=0 at edge N gives earliest iss_vld at edge N+1.
  - Wakeup at edge N gives earliest issue at edge N+1.
- free_cnt: updated each edge to ISQ_DEPTH - popcount(next val).
- Flush at an edge:
  - all val=0, wat=0, iss_vld=0
  - free_cnt=ISQ_DEPTH
  - dispatch, wakeup and issue in the same cycle are discarded
- Full: free_cnt < DISP_PORT drops disp_rdy, even if fewer ports are valid. Empty: iss_vld stays 0.
- No bypass from dispatch to issue within the same cycle.

Test Plan:
- Reset, DEPTH=16, DISP=4, ISS=2 -> free_cnt=16, disp_rdy=1, iss_vld=00, val_out=0.
- Dispatch disp_vld=1010, disp_wat=0000 into an empty queue -> entries 0,1 valid at edge 1. Edge 2: iss_vld=11, idx0=0 with port1 payload, idx1=1 with port3 payload, free_cnt=16.
- Fill 13 entries (free_cnt=3) -> disp_rdy=0. Present disp_vld=1111 -> nothing written. Issue one -> free_cnt=4, disp_rdy=1.
- Entry 5 with wat=1, wakeup[5] pulsed at edge N -> entry not issued at N. Issued at N+1 with idx=5.
- Same-edge dispatch into entry 3 with disp_wat=1 and wakeup[3]=1 -> wat[3]=1 remains, no issue.
- 6 ready entries, iss_stall=1 for 2 cycles then flush -> iss_vld=0 throughout, val_out=0, free_cnt=16, and a same-cycle dispatch is discarded.
